// File: rtl/rom_read_arbiter.sv
// Two-channel read arbiter for a single-port registered block ROM.
// Issues at most one read per cycle and routes each returned word back to its requester by tag.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 12,
    parameter int ROM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    logic                  last_grant_q, last_grant_d;
    logic [ROM_LAT-1:0]    tag_vld_q, tag_vld_d;
    logic [ROM_LAT-1:0]    tag_ch_q, tag_ch_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic                  gnt0, gnt1, accept;
    logic                  fin_vld, fin_ch;

    // last_grant_q: 0 = ch0 was granted last, 1 = ch1; a tie goes to the other one.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (FIXED_PRIO != 0 || last_grant_q) gnt0 = 1'b1;
                else                                 gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept     = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rom_en     = accept;
    assign rom_addr   = gnt0 ? req0_addr : (gnt1 ? req1_addr : rom_addr_q);

    assign fin_vld = tag_vld_q[ROM_LAT-1];
    assign fin_ch  = tag_ch_q[ROM_LAT-1];

    always_comb begin
        last_grant_d = accept ? gnt1 : last_grant_q;
        rom_addr_d   = rom_addr;
        tag_vld_d    = tag_vld_q;
        tag_ch_d     = tag_ch_q;
        for (int i = ROM_LAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ch_d[i]  = tag_ch_q[i-1];
        end
        tag_vld_d[0] = accept;
        tag_ch_d[0]  = gnt1;
        // The final tag stage lines up with the cycle the ROM word is on rom_data.
        rsp0_valid_d = fin_vld && !fin_ch;
        rsp1_valid_d = fin_vld && fin_ch;
        rsp0_data_d  = rsp0_valid_d ? rom_data : rsp0_data_q;
        rsp1_data_d  = rsp1_valid_d ? rom_data : rsp1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            tag_vld_q    <= '0;
            tag_ch_q     <= '0;
            rom_addr_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_vld_q    <= tag_vld_d;
            tag_ch_q     <= tag_ch_d;
            rom_addr_q   <= rom_addr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench: three arbiter instances (defaults, fixed priority, 3-cycle ROM),
// each with its own behavioural ROM returning mem[a] = a[11:0] ^ 12'hA5A.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        v0    [3];
    logic        v1    [3];
    logic [15:0] a0    [3];
    logic [15:0] a1    [3];
    logic        rdy0  [3];
    logic        rdy1  [3];
    logic        rv0   [3];
    logic        rv1   [3];
    logic [11:0] rd0   [3];
    logic [11:0] rd1   [3];
    logic        ren   [3];
    logic [15:0] raddr [3];
    logic [11:0] rom_d [3];
    logic [11:0] rp    [3][4];

    int errors = 0;
    int checks = 0;

    rom_read_arbiter u0 (
        .clk(clk), .rst(rst[0]),
        .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_ready(rdy0[0]),
        .rsp0_valid(rv0[0]), .rsp0_data(rd0[0]),
        .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_ready(rdy1[0]),
        .rsp1_valid(rv1[0]), .rsp1_data(rd1[0]),
        .rom_en(ren[0]), .rom_addr(raddr[0]), .rom_data(rom_d[0]));

    rom_read_arbiter #(.FIXED_PRIO(1)) u1 (
        .clk(clk), .rst(rst[1]),
        .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_ready(rdy0[1]),
        .rsp0_valid(rv0[1]), .rsp0_data(rd0[1]),
        .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_ready(rdy1[1]),
        .rsp1_valid(rv1[1]), .rsp1_data(rd1[1]),
        .rom_en(ren[1]), .rom_addr(raddr[1]), .rom_data(rom_d[1]));

    rom_read_arbiter #(.ROM_LAT(3)) u2 (
        .clk(clk), .rst(rst[2]),
        .req0_valid(v0[2]), .req0_addr(a0[2]), .req0_ready(rdy0[2]),
        .rsp0_valid(rv0[2]), .rsp0_data(rd0[2]),
        .req1_valid(v1[2]), .req1_addr(a1[2]), .req1_ready(rdy1[2]),
        .rsp1_valid(rv1[2]), .rsp1_data(rd1[2]),
        .rom_en(ren[2]), .rom_addr(raddr[2]), .rom_data(rom_d[2]));

    // ROM models: en-gated first stage, then plain delay stages.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ren[k]) rp[k][0] <= raddr[k][11:0] ^ 12'hA5A;
            for (int s = 1; s < 4; s++) rp[k][s] <= rp[k][s-1];
        end
    end
    assign rom_d[0] = rp[0][0];
    assign rom_d[1] = rp[1][0];
    assign rom_d[2] = rp[2][2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic vv0, input logic [15:0] aa0,
                         input logic vv1, input logic [15:0] aa1);
        v0[i] = vv0; a0[i] = aa0;
        v1[i] = vv1; a1[i] = aa1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            drive(i, 1'b0, 16'h0, 1'b0, 16'h0);
        end
        tick(); tick();
        mid();
        chk("rst_rv0", 32'(rv0[0]), 0);
        chk("rst_rd0", 32'(rd0[0]), 0);
        chk("rst_rv1", 32'(rv1[0]), 0);
        chk("rst_ren", 32'(ren[0]), 0);
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        mid();

        // Round-robin tie stream on u0: ch0 first, then alternating.
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(0, k < 6, 16'h0001, k < 6, 16'h0002);
            mid();
            if (k < 6) begin
                chk($sformatf("rr_rdy0_%0d", k), 32'(rdy0[0]), 32'(k % 2 == 0));
                chk($sformatf("rr_rdy1_%0d", k), 32'(rdy1[0]), 32'(k % 2 == 1));
                chk($sformatf("rr_addr_%0d", k), 32'(raddr[0]), (k % 2 == 0) ? 32'h1 : 32'h2);
            end else begin
                chk($sformatf("rr_ren_%0d", k), 32'(ren[0]), 0);
            end
            if (k >= 2) begin
                chk($sformatf("rr_rv0_%0d", k), 32'(rv0[0]), 32'((k - 2) % 2 == 0));
                chk($sformatf("rr_rv1_%0d", k), 32'(rv1[0]), 32'((k - 2) % 2 == 1));
                if ((k - 2) % 2 == 0) chk($sformatf("rr_rd0_%0d", k), 32'(rd0[0]), 32'hA5B);
                else                  chk($sformatf("rr_rd1_%0d", k), 32'(rd1[0]), 32'hA58);
            end
        end

        // Single ch0 read, 2-cycle response latency.
        tick(); drive(0, 1'b1, 16'h0010, 1'b0, 16'h0); mid();
        chk("t1_rdy0", 32'(rdy0[0]), 1);
        chk("t1_rdy1", 32'(rdy1[0]), 0);
        chk("t1_ren", 32'(ren[0]), 1);
        chk("t1_addr", 32'(raddr[0]), 32'h0010);
        tick(); drive(0, 1'b0, 16'h0, 1'b0, 16'h0); mid();
        chk("t1_rv0_early", 32'(rv0[0]), 0);
        tick(); mid();
        chk("t1_rv0", 32'(rv0[0]), 1);
        chk("t1_rd0", 32'(rd0[0]), 32'hA4A);
        chk("t1_rv1", 32'(rv1[0]), 0);
        tick(); mid();
        chk("t1_rv0_pulse", 32'(rv0[0]), 0);
        chk("t1_rd0_hold", 32'(rd0[0]), 32'hA4A);

        // ch1 alone, idle with address held, then tie goes to ch0.
        tick(); drive(0, 1'b0, 16'h0, 1'b1, 16'h0345); mid();
        chk("t6_rdy1", 32'(rdy1[0]), 1);
        chk("t6_addr1", 32'(raddr[0]), 32'h0345);
        tick(); drive(0, 1'b0, 16'h0, 1'b0, 16'h0); mid();
        chk("t6_idle_ren", 32'(ren[0]), 0);
        chk("t6_idle_addr", 32'(raddr[0]), 32'h0345);
        tick(); drive(0, 1'b1, 16'h0777, 1'b1, 16'h0346); mid();
        chk("t6_tie_rdy0", 32'(rdy0[0]), 1);
        chk("t6_tie_rdy1", 32'(rdy1[0]), 0);
        chk("t6_tie_addr", 32'(raddr[0]), 32'h0777);
        chk("t6_rv1", 32'(rv1[0]), 1);
        chk("t6_rd1", 32'(rd1[0]), 32'h91F);
        tick(); drive(0, 1'b0, 16'h0, 1'b0, 16'h0); mid();
        tick(); mid();
        chk("t6_rv0", 32'(rv0[0]), 1);
        chk("t6_rd0", 32'(rd0[0]), 32'hD2D);
        tick(); mid();

        // Accept then reset: in-flight read is dropped, arbitration state restored.
        tick(); drive(0, 1'b1, 16'h0020, 1'b0, 16'h0); mid();
        chk("t5_rdy0", 32'(rdy0[0]), 1);
        tick(); rst[0] = 1'b1; drive(0, 1'b1, 16'h0021, 1'b1, 16'h0022); mid();
        chk("t5_rst_rdy0", 32'(rdy0[0]), 0);
        chk("t5_rst_rdy1", 32'(rdy1[0]), 0);
        chk("t5_rst_ren", 32'(ren[0]), 0);
        tick(); rst[0] = 1'b0; drive(0, 1'b0, 16'h0, 1'b0, 16'h0); mid();
        chk("t5_rv0_a", 32'(rv0[0]), 0);
        chk("t5_rd0", 32'(rd0[0]), 0);
        tick(); mid();
        chk("t5_rv0_b", 32'(rv0[0]), 0);
        tick(); drive(0, 1'b1, 16'h0030, 1'b1, 16'h0031); mid();
        chk("t5_tie_rdy0", 32'(rdy0[0]), 1);
        chk("t5_tie_rdy1", 32'(rdy1[0]), 0);
        tick(); drive(0, 1'b0, 16'h0, 1'b0, 16'h0); mid();

        // Fixed priority on u1: ch0 wins every tie, ch1 served once ch0 drops.
        for (int k = 0; k < 7; k++) begin
            tick();
            drive(1, k < 4, 16'h0001, k < 5, 16'h0002);
            mid();
            if (k < 4) begin
                chk($sformatf("fp_rdy0_%0d", k), 32'(rdy0[1]), 1);
                chk($sformatf("fp_rdy1_%0d", k), 32'(rdy1[1]), 0);
            end else if (k == 4) begin
                chk("fp_rdy1_after", 32'(rdy1[1]), 1);
                chk("fp_rdy0_after", 32'(rdy0[1]), 0);
            end
            if (k >= 2 && k < 6) begin
                chk($sformatf("fp_rv0_%0d", k), 32'(rv0[1]), 1);
                chk($sformatf("fp_rd0_%0d", k), 32'(rd0[1]), 32'hA5B);
                chk($sformatf("fp_rv1_%0d", k), 32'(rv1[1]), 0);
            end
            if (k == 6) begin
                chk("fp_rv1_last", 32'(rv1[1]), 1);
                chk("fp_rd1_last", 32'(rd1[1]), 32'hA58);
                chk("fp_rv0_last", 32'(rv0[1]), 0);
            end
        end

        // ROM_LAT=3 on u2: four back-to-back ch1 reads, responses 4 cycles later in order.
        for (int k = 0; k < 9; k++) begin
            tick();
            drive(2, 1'b0, 16'h0, k < 4, 16'h0100 + 16'(k));
            mid();
            if (k < 4) chk($sformatf("l3_rdy1_%0d", k), 32'(rdy1[2]), 1);
            if (k >= 3) begin
                chk($sformatf("l3_rv1_%0d", k), 32'(rv1[2]), 32'(k >= 4 && k < 8));
                chk($sformatf("l3_rv0_%0d", k), 32'(rv0[2]), 0);
            end
            case (k)
                4: chk("l3_rd1_0", 32'(rd1[2]), 32'hB5A);
                5: chk("l3_rd1_1", 32'(rd1[2]), 32'hB5B);
                6: chk("l3_rd1_2", 32'(rd1[2]), 32'hB58);
                7: chk("l3_rd1_3", 32'(rd1[2]), 32'hB59);
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
